dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Direct-mapped, read-only cache controller that consumes the 11-bit address stream emitted by the trace-driven CPU model and classifies each access as hit or miss. It holds a tag/valid array, issues line fills to a backing-memory model over a request/acknowledge handshake, and keeps saturating statistics counters for the memory-architecture experiments. The block sits between the CPU address source and the backing memory model.

## Interface
- ADDR_W, 11, address width; must equal the CPU address width
- OFFSET_W, 2, block-offset bits (4-byte lines)
- INDEX_W, 4, index bits (16 lines); TAG_W = ADDR_W-INDEX_W-OFFSET_W (5)
- CNT_W, 16, statistics counter width

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  address present this cycle
- req_addr  in  ADDR_W  access address
- ready  out  1  high when a request can be accepted (state IDLE)
- resp_valid  out  1  one-cycle pulse: lookup result available
- resp_hit  out  1  1 = hit, 0 = miss; meaningful only with resp_valid
- resp_addr  out  ADDR_W  address being answered
- mem_req  out  1  line-fill request, held until acknowledged
- mem_addr  out  ADDR_W  block-aligned fill address (offset bits zero)
- mem_ack  in  1  fill complete; sampled only while mem_req=1
- access_count, hit_count, miss_count, drop_count  out  CNT_W  statistics

## Operation
- Address split: offset = addr[OFFSET_W-1:0], index = addr[OFFSET_W+INDEX_W-1:OFFSET_W], tag = upper TAG_W bits.
- Storage: 2^INDEX_W lines, each valid bit + TAG_W tag; no data storage.
- FSM states: IDLE, WAIT.
- IDLE: ready=1. Accept when req_valid=1. Hit = valid[index] && tag match (combinational on req_addr). Hit -> stay IDLE, respond next cycle. Miss -> latch address, go WAIT.
- WAIT: ready=0, mem_req=1, mem_addr = latched address with offset zeroed. On mem_ack=1: write valid=1 and tag into line at index, issue miss response, return IDLE.
- Requests with req_valid=1 while ready=0 are dropped (not queued) and increment drop_count.
- Counters: access_count on every accept; hit_count on hit accept; miss_count on miss accept; all saturate at 2^CNT_W-1 (no wrap).
- mem_ack while mem_req=0 ignored.
- Replacement: a miss unconditionally overwrites the indexed line (conflict eviction).

## Timing
- Reset (async assert, sync-to-clk deassert by the environment): state IDLE, all valid bits 0, all counters 0, ready=1, resp_valid=0, resp_hit=0, resp_addr=0, mem_req=0, mem_addr=0. Reset mid-miss aborts: mem_req falls immediately, no line written, no response.
- Hit latency: accept in cycle N -> resp_valid=1, resp_hit=1, resp_addr=addr in N+1. Back-to-back hits at one per cycle.
- Miss: accept in cycle N -> N+1 mem_req=1, ready=0. mem_ack sampled high in cycle M (M>=N+1) -> M+1: mem_req=0, resp_valid=1, resp_hit=0, ready=1, array updated.
- A request accepted in M+1 sees the just-filled line (same-line access hits).
- Counters update on the edge ending the accept cycle (visible N+1).
- Minimum miss occupancy: 2 cycles (mem_ack in N+1).

## Test plan
- Cold miss: reset, req 0x034 -> N+1 mem_req=1, mem_addr=0x034, ready=0; ack 3 cycles later -> resp_valid, resp_hit=0, resp_addr=0x034; miss_count=1, access_count=1.
- Spatial hit: after fill, req 0x035 -> next cycle resp_hit=1, resp_addr=0x035; hit_count=1; then 0x036, 0x037 back-to-back each hit, ready never low.
- Conflict: 0x034 filled, req 0x434 (index 0xD, tag 0x10) -> miss, mem_addr=0x434; then 0x034 -> miss again; miss_count=3.
- Drops: req_valid held high continuously through a miss with mem_ack 5 cycles after mem_req rises -> drop_count=5, exactly one response for the missed address.
- Reset mid-miss: assert rst_n=0 while mem_req=1 -> mem_req 0 in same cycle without clock; after release req 0x034 misses, all counters restart from 0.
- Saturation: CNT_W=4, 20 hits to a filled line -> hit_count=15, access_count=15 (also saturated), no wrap; stray mem_ack in IDLE has no effect.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only cache controller: classifies each CPU access as hit or miss,
// fetches missed lines from backing memory over a req/ack handshake, keeps saturating stats.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned INDEX_W  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES = 1 << INDEX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

  logic [CNT_W-1:0]  access_q, access_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] miss_index;
  logic [TAG_W-1:0]   miss_tag;

  logic lookup_hit;
  logic accept;
  logic fill;
  logic drop;

  assign req_index  = req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag    = req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign miss_index = miss_addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign miss_tag   = miss_addr_q[ADDR_W-1:OFFSET_W+INDEX_W];

  assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign accept     = req_valid && (state_q == IDLE);
  // mem_ack only counts while the fill request is outstanding
  assign fill       = (state_q == WAIT) && mem_ack;
  assign drop       = req_valid && (state_q == WAIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    miss_addr_d  = miss_addr_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_addr_d  = resp_addr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (lookup_hit) begin
            resp_valid_d = 1'b1;
            resp_hit_d   = 1'b1;
            resp_addr_d  = req_addr;
          end else begin
            miss_addr_d = req_addr;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (fill) begin
          valid_d[miss_index] = 1'b1;
          resp_valid_d        = 1'b1;
          resp_hit_d          = 1'b0;
          resp_addr_d         = miss_addr_q;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    access_d = access_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    drop_d   = drop_q;
    if (accept) begin
      access_d = sat_inc(access_q);
      if (lookup_hit) hit_d = sat_inc(hit_q);
      else            miss_d = sat_inc(miss_q);
    end
    if (drop) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      miss_addr_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_addr_q  <= '0;
      access_q     <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      miss_addr_q  <= miss_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_addr_q  <= resp_addr_d;
      access_q     <= access_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      drop_q       <= drop_d;
    end
  end

  // The tag is written together with the valid bit so a conflict fill evicts the old line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
    end else if (fill) begin
      tag_q[miss_index] <= miss_tag;
    end
  end

  // Handshake outputs decode straight from state so reset drops mem_req without a clock
  assign ready        = (state_q == IDLE);
  assign mem_req      = (state_q == WAIT);
  assign mem_addr     = {miss_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_addr    = resp_addr_q;
  assign access_count = access_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl; a second CNT_W=4 instance shares the
// stimulus to exercise counter saturation.
module tb_dm_cache_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [10:0] req_addr;
  logic        mem_ack;

  logic        ready, resp_valid, resp_hit, mem_req;
  logic [10:0] resp_addr, mem_addr;
  logic [15:0] access_count, hit_count, miss_count, drop_count;

  logic        s_ready, s_resp_valid, s_resp_hit, s_mem_req;
  logic [10:0] s_resp_addr, s_mem_addr;
  logic [3:0]  s_access, s_hit, s_miss, s_drop;

  int total = 0;
  int bad   = 0;
  int resp_seen;

  dm_cache_ctrl #(.ADDR_W(11), .OFFSET_W(2), .INDEX_W(4), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .ready        (ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_addr    (resp_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .access_count (access_count),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .drop_count   (drop_count)
  );

  dm_cache_ctrl #(.ADDR_W(11), .OFFSET_W(2), .INDEX_W(4), .CNT_W(4)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .ready        (s_ready),
    .resp_valid   (s_resp_valid),
    .resp_hit     (s_resp_hit),
    .resp_addr    (s_resp_addr),
    .mem_req      (s_mem_req),
    .mem_addr     (s_mem_addr),
    .mem_ack      (mem_ack),
    .access_count (s_access),
    .hit_count    (s_hit),
    .miss_count   (s_miss),
    .drop_count   (s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [10:0] addr);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
  endtask

  task automatic ack_now();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    repeat (3) step();

    check("rst_ready", ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_addr", resp_addr, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_access", access_count, 0);
    check("rst_drop", drop_count, 0);
    rst_n = 1'b1;
    step();

    // Cold miss on 0x034, ack three cycles after mem_req rises
    issue(11'h034);
    check("cold_mem_req", mem_req, 1);
    check("cold_mem_addr", mem_addr, 11'h034);
    check("cold_ready", ready, 0);
    check("cold_no_resp", resp_valid, 0);
    check("cold_miss_cnt", miss_count, 1);
    check("cold_access_cnt", access_count, 1);
    step();
    step();
    check("cold_still_req", mem_req, 1);
    ack_now();
    check("cold_resp_valid", resp_valid, 1);
    check("cold_resp_hit", resp_hit, 0);
    check("cold_resp_addr", resp_addr, 11'h034);
    check("cold_mem_req_off", mem_req, 0);
    check("cold_ready_back", ready, 1);

    // Spatial hits, the last two back-to-back
    issue(11'h035);
    check("sp1_valid", resp_valid, 1);
    check("sp1_hit", resp_hit, 1);
    check("sp1_addr", resp_addr, 11'h035);
    check("sp1_hit_cnt", hit_count, 1);
    req_valid = 1'b1;
    req_addr  = 11'h036;
    step();
    check("sp2_hit", resp_hit & resp_valid, 1);
    check("sp2_addr", resp_addr, 11'h036);
    check("sp2_ready", ready, 1);
    req_addr = 11'h037;
    step();
    req_valid = 1'b0;
    check("sp3_hit", resp_hit & resp_valid, 1);
    check("sp3_addr", resp_addr, 11'h037);
    check("sp3_ready", ready, 1);
    check("sp_hit_cnt", hit_count, 3);

    // Conflict: 0x434 shares index 0xD with tag 0x10; minimum-latency ack
    issue(11'h434);
    check("cf1_mem_req", mem_req, 1);
    check("cf1_mem_addr", mem_addr, 11'h434);
    ack_now();
    check("cf1_resp", {resp_valid, resp_hit}, 2'b10);
    check("cf1_resp_addr", resp_addr, 11'h434);
    issue(11'h034);
    check("cf2_evicted", mem_req, 1);
    check("cf2_miss_cnt", miss_count, 3);
    ack_now();
    check("cf2_resp_addr", resp_addr, 11'h034);

    // Fill address is block aligned
    issue(11'h1A7);
    check("align_mem_addr", mem_addr, 11'h1A4);
    ack_now();
    check("align_resp_addr", resp_addr, 11'h1A7);

    // Drops: req_valid held through a 5-cycle WAIT, ack in the last WAIT cycle
    req_valid = 1'b1;
    req_addr  = 11'h2B0;
    step();
    resp_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) mem_ack = 1'b1;
      step();
      if (resp_valid && resp_addr == 11'h2B0) resp_seen++;
    end
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    check("drop_cnt", drop_count, 5);
    check("drop_resp_last", {resp_valid, resp_hit}, 2'b10);
    for (int k = 0; k < 3; k++) begin
      step();
      if (resp_valid && resp_addr == 11'h2B0) resp_seen++;
    end
    check("drop_one_resp", resp_seen, 1);
    check("drop_access_cnt", access_count, 8);
    check("drop_miss_cnt", miss_count, 5);

    // Stray mem_ack in IDLE
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("stray_mem_req", mem_req, 0);
    check("stray_resp", resp_valid, 0);
    check("stray_miss_cnt", miss_count, 5);
    check("stray_access_cnt", access_count, 8);

    // Reset in the middle of a miss
    issue(11'h300);
    check("rm_mem_req_pre", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rm_mem_req_async", mem_req, 0);
    check("rm_ready_async", ready, 1);
    check("rm_access_async", access_count, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rm_no_resp", resp_valid, 0);
    issue(11'h034);
    check("rm_cold_again", mem_req, 1);
    check("rm_access_cnt", access_count, 1);
    check("rm_miss_cnt", miss_count, 1);
    check("rm_hit_cnt", hit_count, 0);
    check("rm_drop_cnt", drop_count, 0);
    ack_now();
    check("rm_resp_addr", resp_addr, 11'h034);

    // 20 hits: the 4-bit instance saturates, the 16-bit one does not
    req_valid = 1'b1;
    req_addr  = 11'h035;
    repeat (20) step();
    req_valid = 1'b0;
    check("sat_hit16", hit_count, 20);
    check("sat_access16", access_count, 21);
    check("sat_hit4", s_hit, 15);
    check("sat_access4", s_access, 15);
    check("sat_miss4", s_miss, 1);
    check("sat_drop4", s_drop, 0);
    check("sat_resp4", {s_resp_valid, s_resp_hit}, 2'b11);
    check("sat_resp_addr4", s_resp_addr, 11'h035);
    check("sat_ready4", s_ready, 1);
    check("sat_mem4", {s_mem_req, s_mem_addr}, {1'b0, 11'h034});
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    check("sat_hit4_hold", s_hit, 15);
    check("sat_stray_req", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
